// File: rtl/tt_sweep_pkg.sv
// rtl/tt_sweep_pkg.sv - shared types and sizes for the truth-table sweep capture stage
package tt_sweep_pkg;

  localparam int N_VEC = 16;
  localparam int IDX_W = 4;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

endpackage

// File: rtl/tt_popcount16.sv
// rtl/tt_popcount16.sv - combinational population count of a 16-bit word
module tt_popcount16 (
  input  logic [15:0] i_vec,
  output logic [4:0]  o_cnt
);

  always_comb begin
    o_cnt = '0;
    for (int i = 0; i < 16; i++) begin
      o_cnt = o_cnt + {4'd0, i_vec[i]};
    end
  end

endmodule

// File: rtl/tt_sweep_capture.sv
// rtl/tt_sweep_capture.sv - walks all 16 vectors into a 4-input gate and captures its truth table
module tt_sweep_capture
  import tt_sweep_pkg::*;
#(
  parameter int          SETTLE   = 1,
  parameter logic [15:0] EXPECTED = 16'hEFEB
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [3:0]  dut_in,
  input  logic        dut_out,
  output logic        busy,
  output logic        done,
  output logic [15:0] tt,
  output logic        match,
  output logic [4:0]  mismatch_count
);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(N_VEC - 1);

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [IDX_W-1:0]   r_idx;
  logic [15:0]        r_shreg;
  logic [15:0]        r_tt;
  logic               r_match;
  logic [4:0]         r_mm;
  logic               r_done;
  logic               w_busy;
  logic               w_sample;
  logic               w_finish;
  logic [4:0]         w_mm;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_next = ST_SETTLE;
      ST_SETTLE: if (r_cnt == SETTLE_LAST) w_next = ST_SAMPLE;
      ST_SAMPLE: w_next = (r_idx == IDX_LAST) ? ST_FINISH : ST_SETTLE;
      ST_FINISH: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_busy   = (r_state == ST_SETTLE) || (r_state == ST_SAMPLE);
    w_sample = (r_state == ST_SAMPLE);
    w_finish = (r_state == ST_FINISH);
  end

  tt_popcount16 u_popcount (
    .i_vec (r_shreg ^ EXPECTED),
    .o_cnt (w_mm)
  );

  // The index wraps 15 -> 0 on the last sample, so dut_in is already 0 in FINISH/IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shreg <= '0;
      r_tt    <= '0;
      r_match <= 1'b0;
      r_mm    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (r_state == ST_SETTLE) r_cnt <= r_cnt + 1'b1;
      else                      r_cnt <= '0;
      if (r_state == ST_IDLE && start) begin
        r_idx   <= '0;
        r_shreg <= '0;
      end
      if (w_sample) begin
        r_shreg <= {r_shreg[14:0], dut_out};
        r_idx   <= r_idx + 1'b1;
      end
      if (w_finish) begin
        r_tt    <= r_shreg;
        r_match <= (r_shreg == EXPECTED);
        r_mm    <= w_mm;
      end
    end
  end

  assign dut_in         = r_idx;
  assign busy           = w_busy;
  assign done           = r_done;
  assign tt             = r_tt;
  assign match          = r_match;
  assign mismatch_count = r_mm;

endmodule

// File: tb/tb_tt_sweep_capture.sv
// tb/tb_tt_sweep_capture.sv - self-checking bench for tt_sweep_capture with behavioural gate models
module tb_tt_sweep_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic        start1, start3;
  logic [3:0]  dut_in1, dut_in3;
  logic        dut_out1, dut_out3;
  logic        busy1, busy3, done1, done3;
  logic [15:0] tt1, tt3;
  logic        match1, match3;
  logic [4:0]  mm1, mm3;
  logic [15:0] func1, func3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Gate model: truth-table word with MSB = vector 0
  assign dut_out1 = func1[4'd15 - dut_in1];
  assign dut_out3 = func3[4'd15 - dut_in3];

  tt_sweep_capture #(.SETTLE(1), .EXPECTED(16'hEFEB)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .dut_in(dut_in1), .dut_out(dut_out1),
    .busy(busy1), .done(done1), .tt(tt1), .match(match1), .mismatch_count(mm1)
  );

  tt_sweep_capture #(.SETTLE(3), .EXPECTED(16'hEFEB)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .dut_in(dut_in3), .dut_out(dut_out3),
    .busy(busy3), .done(done3), .tt(tt3), .match(match3), .mismatch_count(mm3)
  );

  typedef struct {
    logic [15:0] func;
    logic [15:0] tt;
    logic        m;
    logic [4:0]  mm;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One sweep on the SETTLE=1 instance, observed on falling edges for 45 cycles.
  task automatic run_sweep(input string tag, input logic [15:0] f, input logic [15:0] prev_tt,
                           input logic chk_prev, input int pulse_at,
                           output logic [15:0] got_tt, output logic got_m, output logic [4:0] got_mm);
    int busy_n = 0;
    int done_n = 0;
    int done_at = -1;
    int seq_bad = 0;
    int idle_bad = 0;
    logic b0 = 1'b0;
    got_tt = '0;
    got_m  = 1'b0;
    got_mm = '0;
    func1  = f;
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int n = 0; n < 45; n++) begin
      if (n > 0) @(negedge clk);
      start1 = (n == pulse_at);
      if (n == 0) begin
        b0 = busy1;
        if (chk_prev) chk({tag, " tt held at start"}, tt1, prev_tt);
      end
      if (busy1) begin
        if (dut_in1 !== 4'(busy_n / 2)) seq_bad++;
        busy_n++;
      end else if (dut_in1 !== 4'd0) begin
        idle_bad++;
      end
      if (done1) begin
        done_n++;
        if (done_at < 0) begin
          done_at = n;
          got_tt  = tt1;
          got_m   = match1;
          got_mm  = mm1;
        end
      end
    end
    start1 = 1'b0;
    chk({tag, " busy after start"}, b0, 1'b1);
    chk({tag, " busy cycles"}, busy_n, 32);
    chk({tag, " done pulses"}, done_n, 1);
    chk({tag, " done cycle"}, done_at, 33);
    chk({tag, " dut_in sequence errs"}, seq_bad, 0);
    chk({tag, " dut_in idle errs"}, idle_bad, 0);
    chk({tag, " tt holds"}, tt1, got_tt);
  endtask

  initial begin
    logic [15:0] g_tt, prev, f, exp_tt;
    logic        g_m, exp_m;
    logic [4:0]  g_mm, exp_mm;
    logic        found;
    int          done_cnt, last_done, gap_bad, run_len, run_bad, runs, seq3_bad, res3_bad, first_done;

    rst = 1'b1; start1 = 1'b0; start3 = 1'b0;
    func1 = 16'hEFEB; func3 = 16'hEFEB;
    repeat (3) @(negedge clk);
    chk("reset busy", {busy1, busy3}, 2'b00);
    chk("reset done", {done1, done3}, 2'b00);
    chk("reset tt", {tt1, tt3}, 32'd0);
    chk("reset match", {match1, match3}, 2'b00);
    chk("reset mm", {mm1, mm3}, 10'd0);
    chk("reset dut_in", {dut_in1, dut_in3}, 8'd0);
    rst = 1'b0;

    tbl[0] = '{16'hEFEB, 16'hEFEB, 1'b1, 5'd0};
    tbl[1] = '{16'hFFFF, 16'hFFFF, 1'b0, 5'd3};
    tbl[2] = '{16'hFFEB, 16'hFFEB, 1'b0, 5'd1};
    tbl[3] = '{16'h0000, 16'h0000, 1'b0, 5'd13};
    tbl[4] = '{16'h1014, 16'h1014, 1'b0, 5'd16};
    tbl[5] = '{16'h6FEB, 16'h6FEB, 1'b0, 5'd1};
    tbl[6] = '{16'hEFEA, 16'hEFEA, 1'b0, 5'd1};

    prev = 16'h0;
    for (int i = 0; i < 7; i++) begin
      run_sweep($sformatf("tbl%0d", i), tbl[i].func, prev, 1'b1, -1, g_tt, g_m, g_mm);
      chk($sformatf("tbl%0d tt", i), g_tt, tbl[i].tt);
      chk($sformatf("tbl%0d match", i), g_m, tbl[i].m);
      chk($sformatf("tbl%0d mm", i), g_mm, tbl[i].mm);
      prev = tbl[i].tt;
    end

    for (int i = 0; i < 8; i++) begin
      f      = 16'($urandom);
      exp_tt = f;
      exp_m  = (f == 16'hEFEB);
      exp_mm = 5'($countones(f ^ 16'hEFEB));
      run_sweep($sformatf("rnd%0d", i), f, prev, 1'b1, -1, g_tt, g_m, g_mm);
      chk($sformatf("rnd%0d tt", i), g_tt, exp_tt);
      chk($sformatf("rnd%0d match", i), g_m, exp_m);
      chk($sformatf("rnd%0d mm", i), g_mm, exp_mm);
      prev = exp_tt;
    end

    run_sweep("restart", 16'hEFEB, prev, 1'b1, 10, g_tt, g_m, g_mm);
    chk("restart tt", g_tt, 16'hEFEB);
    chk("restart match", g_m, 1'b1);

    // Abort a sweep with reset while vector 7 is applied
    func1 = 16'hEFEB;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      if (dut_in1 == 4'd7) found = 1'b1;
      else @(negedge clk);
    end
    chk("abort reached idx7", found, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("abort busy", busy1, 1'b0);
    chk("abort dut_in", dut_in1, 4'd0);
    chk("abort tt", tt1, 16'd0);
    chk("abort match/mm", {match1, mm1}, 6'd0);
    @(negedge clk); rst = 1'b0;
    done_cnt = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done1 || busy1) done_cnt++;
    end
    chk("abort no done/busy", done_cnt, 0);
    run_sweep("post_abort", 16'hEFEB, 16'h0, 1'b1, -1, g_tt, g_m, g_mm);
    chk("post_abort tt", g_tt, 16'hEFEB);
    chk("post_abort mm", {g_m, g_mm}, {1'b1, 5'd0});

    // SETTLE=3 instance with start held high: back-to-back sweeps
    @(negedge clk); start3 = 1'b1;
    done_cnt = 0; last_done = -1; gap_bad = 0; run_len = 0; run_bad = 0; runs = 0;
    seq3_bad = 0; res3_bad = 0; first_done = -1;
    for (int n = 1; n <= 220; n++) begin
      @(negedge clk);
      if (busy3) begin
        if (dut_in3 !== 4'(run_len / 4)) seq3_bad++;
        run_len++;
      end else begin
        if (run_len != 0) begin
          runs++;
          if (run_len != 64) run_bad++;
        end
        run_len = 0;
      end
      if (done3) begin
        done_cnt++;
        if (first_done < 0) first_done = n;
        if (last_done >= 0 && n - last_done != 66) gap_bad++;
        last_done = n;
        if (tt3 !== 16'hEFEB || match3 !== 1'b1 || mm3 !== 5'd0) res3_bad++;
      end
    end
    start3 = 1'b0;
    chk("s3 first done", first_done, 66);
    chk("s3 done count", done_cnt, 3);
    chk("s3 done spacing errs", gap_bad, 0);
    chk("s3 busy runs", runs, 3);
    chk("s3 busy length errs", run_bad, 0);
    chk("s3 dut_in hold errs", seq3_bad, 0);
    chk("s3 result errs", res3_bad, 0);
    repeat (80) @(negedge clk);
    chk("s3 idle after release", busy3, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
